conv_pe_feeder: RTL and testbench
=================================

# conv_pe_feeder

Sequencer that drives one 3x3 convolution PE (`conv_pe_sr`-style consumer) from two synchronous on-chip memories. On a start pulse it reads the nine kernel weights and emits them on `weight_out`, then streams the full feature map in row-major order on `data_out`. It holds the PE in reset outside the active window and pulses `done` when the frame is finished. It sits between the layer controller and the PE array, one instance per PE column.

## Interface
- `WIDTH`, 9, bit width of weights and pixels.
- `IMG_W`, 12, feature-map width in pixels.
- `IMG_H`, 8, feature-map height in pixels; N = IMG_W*IMG_H = 96.
- `ADDR_W`, 7, image address width; must satisfy 2^ADDR_W >= N.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request to run a frame.
- `busy` out 1: high while a frame is in progress.
- `done` out 1: one-cycle pulse at frame end.
- `wt_rd_en` out 1: weight memory read enable.
- `wt_addr` out 4: weight address, 0..8.
- `wt_rdata` in WIDTH: weight memory data; valid the cycle after the address.
- `img_rd_en` out 1: image memory read enable.
- `img_addr` out ADDR_W: pixel address, 0..N-1.
- `img_rdata` in WIDTH: image memory data; valid the cycle after the address.
- `weight_out` out WIDTH: weight to the PE; 0 when `weight_valid` is low.
- `weight_valid` out 1: `weight_out` carries a tap.
- `data_out` out WIDTH: pixel to the PE; 0 when `data_valid` is low.
- `data_valid` out 1: `data_out` carries a pixel.
- `data_last` out 1: high with the final pixel (address N-1).
- `pe_rst_n` out 1: active-low reset for the PE.

## Operation
- FSM states:
  - IDLE -> LOAD_W on `start`.
  - LOAD_W: 9 cycles, `wt_addr` 0..8, `wt_rd_en`=1. Then -> GAP.
  - GAP: 1 cycle, no reads. Then -> STREAM.
  - STREAM: N cycles, `img_addr` 0..N-1, `img_rd_en`=1. Then -> DRAIN.
  - DRAIN: 2 cycles. Then -> DONE.
  - DONE: 1 cycle, `done`=1. Then -> IDLE.
- `start` is sampled only in IDLE. It is ignored in every other state, including the DONE cycle.
- Read data is registered once before output. Each output beat appears two cycles after its address.
- Output order is strictly by address: weights tap 0..8, pixels row-major. No reordering and no backpressure.
- Address counters saturate at their terminal value and clear on leaving their state. Wrap-around never occurs.
- `pe_rst_n` goes high with the first `weight_valid` and stays high through the last `data_valid`. It is low in every other cycle.
- Zero-valued weights are still flagged by `weight_valid`.
- Asserting `rst_n` at any point aborts the frame immediately. No partial `done` is produced.

## Timing
- Reset values: `busy`, `done`, `wt_rd_en`, `img_rd_en`, `weight_valid`, `data_valid`, `data_last` = 0. `wt_addr`, `img_addr`, `weight_out`, `data_out` = 0. `pe_rst_n` = 0. FSM = IDLE.
- Let `start` be sampled at edge k:
  - LOAD_W occupies cycles k+1..k+9.
  - `weight_valid` is high in cycles k+3..k+11, carrying taps 0..8.
  - GAP is cycle k+10; STREAM occupies cycles k+11..k+10+N.
  - `data_valid` is high in cycles k+13..k+12+N; `data_last` is high in cycle k+12+N.
  - `done` is high in cycle k+13+N.
  - `busy` is high in cycles k+1..k+13+N.
  - `pe_rst_n` is high in cycles k+3..k+12+N.
- `weight_valid` and `data_valid` are never high in the same cycle. The gap between tap 8 and pixel 0 is exactly one cycle.
- For N=96, frame length from `start` to `done` is 109 cycles.

## Structure
- Shared package `conv_pkg` holds:
  - the state enum (IDLE, LOAD_W, GAP, STREAM, DRAIN, DONE);
  - `KERNEL_TAPS`=9;
  - `DRAIN_CYC`=2.
- Single module, no sub-module. The two-stage read pipeline (valid/last shift bits plus data register) is inline.

## Test plan
- Weight memory holds 1..9 and pixel memory holds addr+1. `start` at edge k -> `weight_out` = 1..9 in cycles k+3..k+11, `data_out` = 1..96 in cycles k+13..k+108, `data_last` only with 96, `done` in cycle k+109.
- Weight memory holds 0 at taps 2 and 5 -> `weight_valid` stays high for all 9 taps, with `weight_out`=0 at taps 2 and 5.
- `start` held high through the whole frame, and pulsed again in the DONE cycle -> exactly one frame runs. A new `start` in cycle k+110 begins a second frame with identical timing.
- `rst_n` low in cycle k+50 (mid-STREAM):
  - all outputs return to reset values asynchronously;
  - no `done` is produced;
  - after release, `start` runs a clean frame beginning at tap 0.
- `start` with reset held low -> no reads, all outputs stay 0.
- Full-frame check against a PE model:
  - `pe_rst_n` low in cycle k+2 and in cycle k+13+N, high in between;
  - `busy` deasserts in cycle k+14+N.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and constants for the conv PE feeder.
// Revision    : 1.0  initial release
// ============================================================================
package conv_pkg;

    localparam int KERNEL_TAPS = 9;
    localparam int DRAIN_CYC   = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_GAP    = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_pe_feeder.sv
`default_nettype none
// ============================================================================
// Module      : conv_pe_feeder
// Description : Reads 9 kernel taps then a full feature map and feeds one PE.
// Revision    : 1.0  initial release
// ============================================================================
module conv_pe_feeder
    import conv_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int IMG_W  = 12,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_wt_rd_en,
    output logic [3:0]        o_wt_addr,
    input  logic [WIDTH-1:0]  i_wt_rdata,
    output logic              o_img_rd_en,
    output logic [ADDR_W-1:0] o_img_addr,
    input  logic [WIDTH-1:0]  i_img_rdata,
    output logic [WIDTH-1:0]  o_weight_out,
    output logic              o_weight_valid,
    output logic [WIDTH-1:0]  o_data_out,
    output logic              o_data_valid,
    output logic              o_data_last,
    output logic              o_pe_rst_n
);

    localparam int                c_N          = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] c_IMG_LAST   = ADDR_W'(c_N - 1);
    localparam logic [3:0]        c_WT_LAST    = 4'(KERNEL_TAPS - 1);
    localparam logic [1:0]        c_DRAIN_LAST = 2'(DRAIN_CYC - 1);

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_wt_rd_en;
    logic [3:0]          r_wt_addr;
    logic                r_img_rd_en;
    logic [ADDR_W-1:0]   r_img_addr;
    logic [1:0]          r_drain_cnt;

    logic                r_wt_v1;
    logic                r_img_v1;
    logic                r_img_last1;
    logic                r_weight_valid;
    logic [WIDTH-1:0]    r_weight_out;
    logic                r_data_valid;
    logic [WIDTH-1:0]    r_data_out;
    logic                r_data_last;
    logic                r_pe_rst_n;

    // Sequencer: every read-side output is registered straight out of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wt_rd_en  <= 1'b0;
            r_wt_addr   <= '0;
            r_img_rd_en <= 1'b0;
            r_img_addr  <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state    <= ST_LOAD_W;
                        r_busy     <= 1'b1;
                        r_wt_rd_en <= 1'b1;
                        r_wt_addr  <= '0;
                    end
                end
                ST_LOAD_W: begin
                    if (r_wt_addr == c_WT_LAST) begin
                        r_state    <= ST_GAP;
                        r_wt_rd_en <= 1'b0;
                        r_wt_addr  <= '0;
                    end else begin
                        r_wt_addr <= r_wt_addr + 4'd1;
                    end
                end
                ST_GAP: begin
                    r_state     <= ST_STREAM;
                    r_img_rd_en <= 1'b1;
                    r_img_addr  <= '0;
                end
                ST_STREAM: begin
                    if (r_img_addr == c_IMG_LAST) begin
                        r_state     <= ST_DRAIN;
                        r_img_rd_en <= 1'b0;
                        r_img_addr  <= '0;
                        r_drain_cnt <= '0;
                    end else begin
                        r_img_addr <= r_img_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_wt_rd_en  <= 1'b0;
                    r_img_rd_en <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage read pipeline: memory latency stage, then output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wt_v1        <= 1'b0;
            r_img_v1       <= 1'b0;
            r_img_last1    <= 1'b0;
            r_weight_valid <= 1'b0;
            r_weight_out   <= '0;
            r_data_valid   <= 1'b0;
            r_data_out     <= '0;
            r_data_last    <= 1'b0;
            r_pe_rst_n     <= 1'b0;
        end else begin
            r_wt_v1        <= r_wt_rd_en;
            r_img_v1       <= r_img_rd_en;
            r_img_last1    <= r_img_rd_en && (r_img_addr == c_IMG_LAST);
            r_weight_valid <= r_wt_v1;
            r_weight_out   <= r_wt_v1 ? i_wt_rdata : '0;
            r_data_valid   <= r_img_v1;
            r_data_out     <= r_img_v1 ? i_img_rdata : '0;
            r_data_last    <= r_img_last1;
            // Last term bridges the one-cycle hole between tap 8 and pixel 0.
            r_pe_rst_n     <= r_wt_v1 | r_img_v1 |
                              (r_weight_valid & (r_state == ST_STREAM));
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_wt_rd_en     = r_wt_rd_en;
    assign o_wt_addr      = r_wt_addr;
    assign o_img_rd_en    = r_img_rd_en;
    assign o_img_addr     = r_img_addr;
    assign o_weight_out   = r_weight_out;
    assign o_weight_valid = r_weight_valid;
    assign o_data_out     = r_data_out;
    assign o_data_valid   = r_data_valid;
    assign o_data_last    = r_data_last;
    assign o_pe_rst_n     = r_pe_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_conv_pe_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_pe_feeder
// Description : Cycle-exact scoreboard bench for conv_pe_feeder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_conv_pe_feeder;

    localparam int WIDTH  = 9;
    localparam int IMG_W  = 12;
    localparam int IMG_H  = 8;
    localparam int ADDR_W = 7;
    localparam int N      = IMG_W * IMG_H;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              busy, done;
    logic              wt_rd_en;
    logic [3:0]        wt_addr;
    logic [WIDTH-1:0]  wt_rdata;
    logic              img_rd_en;
    logic [ADDR_W-1:0] img_addr;
    logic [WIDTH-1:0]  img_rdata;
    logic [WIDTH-1:0]  weight_out;
    logic              weight_valid;
    logic [WIDTH-1:0]  data_out;
    logic              data_valid;
    logic              data_last;
    logic              pe_rst_n;

    conv_pe_feeder #(
        .WIDTH (WIDTH),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .o_busy        (busy),
        .o_done        (done),
        .o_wt_rd_en    (wt_rd_en),
        .o_wt_addr     (wt_addr),
        .i_wt_rdata    (wt_rdata),
        .o_img_rd_en   (img_rd_en),
        .o_img_addr    (img_addr),
        .i_img_rdata   (img_rdata),
        .o_weight_out  (weight_out),
        .o_weight_valid(weight_valid),
        .o_data_out    (data_out),
        .o_data_valid  (data_valid),
        .o_data_last   (data_last),
        .o_pe_rst_n    (pe_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories with one-cycle read latency.
    logic [WIDTH-1:0] wt_mem  [0:15];
    logic [WIDTH-1:0] img_mem [0:127];
    always @(posedge clk) begin
        if (wt_rd_en)  wt_rdata  <= wt_mem[wt_addr];
        if (img_rd_en) img_rdata <= img_mem[img_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [63:0] v;
    } exp_t;
    exp_t sb[$];

    function automatic logic [63:0] pack(
        input logic rd_w, input logic [3:0] aw, input logic rd_i, input logic [ADDR_W-1:0] ai,
        input logic b, input logic d, input logic pe, input logic wv, input logic [WIDTH-1:0] w,
        input logic dv, input logic [WIDTH-1:0] dd, input logic last);
        return {27'd0, rd_w, aw, rd_i, ai, b, d, pe, wv, w, dv, dd, last};
    endfunction

    function automatic logic [63:0] observed();
        return pack(wt_rd_en, wt_addr, img_rd_en, img_addr, busy, done, pe_rst_n,
                    weight_valid, weight_out, data_valid, data_out, data_last);
    endfunction

    // Expected per-cycle outputs for a frame whose start is sampled at edge k.
    task automatic push_frame(input int k);
        exp_t r;
        for (int t = 1; t <= 13 + N; t++) begin
            logic              rw, ri, wv, dv;
            logic [3:0]        aw;
            logic [ADDR_W-1:0] ai;
            logic [WIDTH-1:0]  w, d;
            rw = (t >= 1) && (t <= 9);
            aw = rw ? 4'(t - 1) : 4'd0;
            ri = (t >= 11) && (t <= 10 + N);
            ai = ri ? ADDR_W'(t - 11) : '0;
            wv = (t >= 3) && (t <= 11);
            w  = wv ? wt_mem[t - 3] : '0;
            dv = (t >= 13) && (t <= 12 + N);
            d  = dv ? img_mem[t - 13] : '0;
            r.cyc = k + t;
            r.v   = pack(rw, aw, ri, ai, 1'b1, t == 13 + N, (t >= 3) && (t <= 12 + N),
                         wv, w, dv, d, t == 12 + N);
            sb.push_back(r);
        end
    endtask

    // Outside a scheduled frame every output must be at its idle value.
    always @(negedge clk) begin
        logic [63:0] exp;
        int now;
        now = cyc + 1;
        exp = '0;
        if (sb.size() > 0 && sb[0].cyc == now) begin
            exp = sb[0].v;
            void'(sb.pop_front());
        end
        check_eq($sformatf("cycle%0d", now), observed(), exp);
    end

    task automatic fill_mems(input bit rand_img);
        for (int i = 0; i < 16; i++)  wt_mem[i]  = (i < 9) ? WIDTH'(i + 1) : '0;
        for (int i = 0; i < 128; i++) img_mem[i] = rand_img ? WIDTH'($urandom) : WIDTH'(i + 1);
    endtask

    task automatic run_frame();
        int k;
        k = cyc + 1;
        start = 1'b1;
        push_frame(k);
        @(negedge clk);
        start = 1'b0;
        repeat (N + 14) @(negedge clk);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        fill_mems(1'b0);
        repeat (3) @(negedge clk);
        check_eq("reset_state", observed(), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame with weights 1..9 and pixels addr+1.
        run_frame();

        // Zero-valued taps are still flagged valid.
        wt_mem[2] = '0;
        wt_mem[5] = '0;
        run_frame();

        // Start held through the whole frame including DONE; re-sampled at k+110.
        fill_mems(1'b1);
        k = cyc + 1;
        start = 1'b1;
        push_frame(k);
        repeat (110) @(negedge clk);
        push_frame(k + 110);
        @(negedge clk);
        start = 1'b0;
        repeat (N + 14) @(negedge clk);

        // Asynchronous abort in cycle k+50, mid-STREAM.
        k = cyc + 1;
        start = 1'b1;
        push_frame(k);
        @(negedge clk);
        start = 1'b0;
        repeat (48) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_eq("async_abort", observed(), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean frame after abort starts from tap 0.
        fill_mems(1'b1);
        run_frame();

        // Start while reset is held must do nothing.
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
